ndrot_pulse_driver: RTL and testbench

NDROT_PULSE_DRIVER -- requirements
Module: ndrot_pulse_driver

---
 rtl/ndrot_pulse_driver.sv | 140 ++++++++++++++
 tb/tb_ndrot_pulse_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ndrot_pulse_driver.sv
// Command-driven pulse generator for an NDRO toggle cell: SET/CLEAR/READ become
// single level changes on a_o/b_o/clk_o, READ results come back as q_i toggles.
module ndrot_pulse_driver #(
  parameter int GAP_CYCLES = 4,
  parameter int Q_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  output logic        a_o,
  output logic        b_o,
  output logic        clk_o,
  input  logic        q_i,
  output logic        rsp_valid,
  output logic        rsp_bit,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] pulse_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_Q, GAP} state_t;

  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(Q_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       shadow_q, shadow_d;
  logic       q_s1, q_s2, q_s3;
  logic       toggle;
  logic       fire_a, fire_b, fire_c;
  logic       rsp_fire, rsp_d;
  logic       err_set;

  // q_s1/q_s2 resynchronise the asynchronous cell output; q_s3 holds the previous level
  assign toggle    = q_s2 ^ q_s3;
  assign cmd_ready = (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    fire_a   = 1'b0;
    fire_b   = 1'b0;
    fire_c   = 1'b0;
    rsp_fire = 1'b0;
    rsp_d    = rsp_bit;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        err_set = toggle;
        if (cmd_valid) begin
          case (cmd_op)
            OP_SET: begin
              fire_a   = 1'b1;
              shadow_d = 1'b1;
              state_d  = GAP;
              cnt_d    = 8'd0;
            end
            OP_CLEAR: begin
              fire_b   = 1'b1;
              shadow_d = 1'b0;
              state_d  = GAP;
              cnt_d    = 8'd0;
            end
            OP_READ: begin
              fire_c  = 1'b1;
              state_d = WAIT_Q;
              cnt_d   = 8'd0;
            end
            default: ;
          endcase
        end
      end
      WAIT_Q: begin
        // A toggle arriving on the timeout cycle still counts as seen
        if (toggle || (cnt_q == TMO_LAST)) begin
          rsp_fire = 1'b1;
          rsp_d    = toggle;
          err_set  = (toggle != shadow_q);
          state_d  = GAP;
          cnt_d    = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        err_set = toggle;
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      shadow_q  <= 1'b0;
      q_s1      <= 1'b0;
      q_s2      <= 1'b0;
      q_s3      <= 1'b0;
      a_o       <= 1'b0;
      b_o       <= 1'b0;
      clk_o     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_bit   <= 1'b0;
      err       <= 1'b0;
      pulse_cnt <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      q_s1      <= q_i;
      q_s2      <= q_s1;
      q_s3      <= q_s2;
      a_o       <= a_o ^ fire_a;
      b_o       <= b_o ^ fire_b;
      clk_o     <= clk_o ^ fire_c;
      rsp_valid <= rsp_fire;
      rsp_bit   <= rsp_d;
      // A fresh error wins over a simultaneous clear
      err       <= err_set | (err & ~err_clr);
      if (fire_a || fire_b || fire_c) begin
        pulse_cnt <= pulse_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ndrot_pulse_driver.sv
// Directed bench for ndrot_pulse_driver: stimulus queues expected READ responses,
// a negedge monitor pops and compares them whenever rsp_valid is seen.
module tb_ndrot_pulse_driver;

  localparam int GAP = 4;
  localparam int TMO = 16;

  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] SET   = 2'b01;
  localparam logic [1:0] CLEAR = 2'b10;
  localparam logic [1:0] READ  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic        a_o, b_o, clk_o;
  logic        q_i;
  logic        rsp_valid, rsp_bit, err;
  logic        err_clr;
  logic [15:0] pulse_cnt;

  typedef struct {
    logic bitv;
    logic errv;
    int   cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  logic       ea, eb, ec;
  logic [15:0] ecnt;

  ndrot_pulse_driver #(.GAP_CYCLES(GAP), .Q_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .a_o       (a_o),
    .b_o       (b_o),
    .clk_o     (clk_o),
    .q_i       (q_i),
    .rsp_valid (rsp_valid),
    .rsp_bit   (rsp_bit),
    .err       (err),
    .err_clr   (err_clr),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_bit", {31'd0, rsp_bit}, {31'd0, e.bitv});
        chk("rsp_err", {31'd0, err}, {31'd0, e.errv});
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Offer a command, wait for acceptance, return the accepting edge index
  task automatic issue(input logic [1:0] op, output int e);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'd1, 32'd0);
    e = cyc + 1;
    case (op)
      SET:     begin ea = ~ea; ecnt = ecnt + 16'd1; end
      CLEAR:   begin eb = ~eb; ecnt = ecnt + 16'd1; end
      READ:    begin ec = ~ec; ecnt = ecnt + 16'd1; end
      default: ;
    endcase
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_pulses(input string tag);
    chk({tag, "_a_o"}, {31'd0, a_o}, {31'd0, ea});
    chk({tag, "_b_o"}, {31'd0, b_o}, {31'd0, eb});
    chk({tag, "_clk_o"}, {31'd0, clk_o}, {31'd0, ec});
    chk({tag, "_cnt"}, {16'd0, pulse_cnt}, {16'd0, ecnt});
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("rsp_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_o"}, {31'd0, a_o}, 32'd0);
    chk({tag, "_b_o"}, {31'd0, b_o}, 32'd0);
    chk({tag, "_clk_o"}, {31'd0, clk_o}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_bit"}, {31'd0, rsp_bit}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, pulse_cnt}, 32'd0);
  endtask

  initial begin
    int e, e1, low;
    exp_t x;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; q_i = 1'b0; err_clr = 1'b0;
    ea = 1'b0; eb = 1'b0; ec = 1'b0; ecnt = 16'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // NOP: no pulse, stays ready
    issue(NOP, e);
    chk_pulses("nop");
    chk("nop_ready", {31'd0, cmd_ready}, 32'd1);

    // SET then READ with a q_i toggle two cycles after clk_o
    issue(SET, e);
    chk_pulses("set1");
    issue(READ, e);
    chk_pulses("read1");
    x.bitv = 1'b1; x.errv = 1'b0; x.cyc = e + 5;
    sbq.push_back(x);
    repeat (2) @(posedge clk);
    @(negedge clk);
    q_i = ~q_i;
    wait_rsp();
    repeat (3) @(negedge clk);
    chk("rsp_bit_hold", {31'd0, rsp_bit}, 32'd1);
    chk("err_after_read1", {31'd0, err}, 32'd0);

    // CLEAR then READ, no toggle: timeout 16 cycles after acceptance, no error
    issue(CLEAR, e);
    chk_pulses("clear2");
    issue(READ, e);
    x.bitv = 1'b0; x.errv = 1'b0; x.cyc = e + TMO;
    sbq.push_back(x);
    wait_rsp();
    chk_pulses("read2");

    // SET then READ, no toggle: mismatch with shadow raises err, err_clr drops it
    issue(SET, e);
    issue(READ, e);
    x.bitv = 1'b0; x.errv = 1'b1; x.cyc = e + TMO;
    sbq.push_back(x);
    wait_rsp();
    @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);

    // Back-to-back SET, CLEAR with cmd_valid held
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = SET;
    low = 0;
    while (!cmd_ready && low < 50) begin @(negedge clk); low++; end
    e1 = cyc + 1;
    ea = ~ea; ecnt = ecnt + 16'd1;
    @(negedge clk);
    chk("b2b_a_o", {31'd0, a_o}, {31'd0, ea});
    cmd_op = CLEAR;
    low = 0;
    while (!cmd_ready && low < 50) begin low++; @(negedge clk); end
    eb = ~eb; ecnt = ecnt + 16'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_ready_low", low, GAP);
    chk_pulses("b2b");
    repeat (GAP + 1) @(negedge clk);

    // Spurious toggle in IDLE sets err; a second one wins over a simultaneous clear
    q_i = ~q_i;
    repeat (4) @(negedge clk);
    chk("spurious_err", {31'd0, err}, 32'd1);
    q_i = ~q_i;
    repeat (2) @(posedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_priority", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clear2", {31'd0, err}, 32'd0);

    // Reset during WAIT_Q abandons the READ
    issue(READ, e);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_waitq");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ea = 1'b0; eb = 1'b0; ec = 1'b0; ecnt = 16'd0;
    @(posedge clk); #1;
    chk("ready_after_rst2", {31'd0, cmd_ready}, 32'd1);
    repeat (TMO + 4) @(negedge clk);

    // pulse_cnt wrap 0xFFFF -> 0x0000
    @(negedge clk);
    force dut.pulse_cnt = 16'hFFFF;
    #1;
    release dut.pulse_cnt;
    ecnt = 16'hFFFF;
    issue(SET, e);
    chk_pulses("wrap");
    repeat (GAP + 2) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
